// File: rtl/chain_link_controller_pkg.sv
// Shared definitions for the chain link controller: FSM state encoding,
// result codes and a saturating counter helper.
package chain_link_controller_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DEC_ARM  = 3'd1,
    S_ENC_KICK = 3'd2,
    S_RUN      = 3'd3,
    S_CHECK    = 3'd4,
    S_FINISH   = 3'd5
  } state_t;

  typedef logic [2:0] status_t;

  localparam status_t STATUS_OK       = 3'd0;
  localparam status_t STATUS_ENC_ERR  = 3'd1;
  localparam status_t STATUS_DEC_ERR  = 3'd2;
  localparam status_t STATUS_TIMEOUT  = 3'd3;
  localparam status_t STATUS_MISMATCH = 3'd4;
  localparam status_t STATUS_ABORT    = 3'd5;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/chain_link_controller_link_watchdog.sv
// Watchdog counter for one encode/decode transaction. expire_o fires in the
// cycle whose increment brings the count up to LIMIT, so the owner can leave
// its state on exactly the LIMIT-th enabled cycle.
module chain_link_controller_link_watchdog #(
  parameter int unsigned LIMIT = 1000000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clear_i,
  input  logic                           enable_i,
  input  logic                           load_i,
  input  logic [$clog2(LIMIT+1)-1:0]     load_value_i,
  output logic                           expire_o
);

  localparam int unsigned W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LIMIT_W    = W'(LIMIT);
  localparam logic [W-1:0] LIMIT_M1_W = W'(LIMIT - 1);

  logic [W-1:0] count_q;

  // Counter: clear wins over load, load wins over counting; holds at LIMIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_value_i;
    end else if (enable_i && (count_q != LIMIT_W)) begin
      count_q <= count_q + W'(1);
    end
  end

  assign expire_o = enable_i && (count_q >= LIMIT_M1_W);

endmodule

// File: rtl/chain_link_controller.sv
// Sequences one encoder/decoder transaction over the serial chain link:
// arms the decoder, kicks the encoder, collects metrics and packet counts,
// and reports a result code with a single-cycle done pulse.
module chain_link_controller
  import chain_link_controller_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES   = 1000000,
  parameter int unsigned DEC_RESET_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        abort,
  output logic        enc_start,
  input  logic        enc_done,
  input  logic        enc_error,
  input  logic [15:0] enc_perimiter,
  input  logic [15:0] enc_area,
  input  logic [5:0]  enc_start_x,
  input  logic [5:0]  enc_start_y,
  output logic        dec_reset,
  output logic        dec_start,
  input  logic        dec_packet_done,
  input  logic        dec_done,
  input  logic        dec_error,
  output logic        busy,
  output logic        done,
  output logic [2:0]  status,
  output logic [15:0] packet_count,
  output logic [15:0] res_perimiter,
  output logic [15:0] res_area,
  output logic [5:0]  res_x,
  output logic [5:0]  res_y
);

  localparam int unsigned AW = $clog2(DEC_RESET_CYCLES + 1);
  localparam logic [AW-1:0] ARM_LAST = AW'(DEC_RESET_CYCLES - 1);

  state_t        state_q, state_d;
  status_t       status_q, status_d;
  logic [AW-1:0] arm_cnt_q;
  logic [15:0]   packet_count_q;
  logic          enc_seen_q, dec_seen_q;
  logic [15:0]   res_perimiter_q, res_area_q;
  logic [5:0]    res_x_q, res_y_q;
  logic          wd_clear, wd_enable, wd_expire;
  logic          both_seen;

  chain_link_controller_link_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (wd_clear),
    .enable_i     (wd_enable),
    .load_i       (1'b0),
    .load_value_i ('0),
    .expire_o     (wd_expire)
  );

  // Completion may be seen in this very cycle, so fold in the live strobes.
  assign both_seen = (enc_seen_q | enc_done) & (dec_seen_q | dec_done);

  // State and result-code registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      status_q <= STATUS_OK;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
    end
  end

  // Next state, result code and decoded outputs; cause priority follows the
  // order of the if-chains (abort first, mismatch last).
  always_comb begin
    state_d   = state_q;
    status_d  = status_q;
    wd_clear  = 1'b0;
    wd_enable = 1'b0;
    enc_start = 1'b0;
    dec_start = 1'b0;
    dec_reset = reset;
    done      = 1'b0;
    busy      = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d  = S_DEC_ARM;
          wd_clear = 1'b1;
        end
      end
      S_DEC_ARM: begin
        dec_reset = 1'b1;
        wd_clear  = 1'b1;
        if (abort) begin
          state_d  = S_FINISH;
          status_d = STATUS_ABORT;
        end else if (arm_cnt_q == ARM_LAST) begin
          state_d = S_ENC_KICK;
        end
      end
      S_ENC_KICK: begin
        enc_start = 1'b1;
        dec_start = 1'b1;
        wd_enable = 1'b1;
        if (abort) begin
          state_d  = S_FINISH;
          status_d = STATUS_ABORT;
        end else if (wd_expire) begin
          state_d  = S_FINISH;
          status_d = STATUS_TIMEOUT;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        dec_start = 1'b1;
        wd_enable = 1'b1;
        if (abort) begin
          state_d  = S_FINISH;
          status_d = STATUS_ABORT;
        end else if (enc_error) begin
          state_d  = S_FINISH;
          status_d = STATUS_ENC_ERR;
        end else if (dec_error) begin
          state_d  = S_FINISH;
          status_d = STATUS_DEC_ERR;
        end else if (wd_expire) begin
          state_d  = S_FINISH;
          status_d = STATUS_TIMEOUT;
        end else if (both_seen) begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        dec_start = 1'b1;
        state_d   = S_FINISH;
        if (abort) begin
          status_d = STATUS_ABORT;
        end else if (packet_count_q != res_perimiter_q) begin
          status_d = STATUS_MISMATCH;
        end else begin
          status_d = STATUS_OK;
        end
      end
      S_FINISH: begin
        done    = 1'b1;
        state_d = S_IDLE;
        if (status_q != STATUS_OK) begin
          dec_reset = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Datapath: arm timer, packet counter, sticky completion flags, metrics.
  always_ff @(posedge clk) begin
    if (reset) begin
      arm_cnt_q       <= '0;
      packet_count_q  <= '0;
      enc_seen_q      <= 1'b0;
      dec_seen_q      <= 1'b0;
      res_perimiter_q <= '0;
      res_area_q      <= '0;
      res_x_q         <= '0;
      res_y_q         <= '0;
    end else begin
      if (state_q == S_IDLE && run) begin
        arm_cnt_q      <= '0;
        packet_count_q <= '0;
        enc_seen_q     <= 1'b0;
        dec_seen_q     <= 1'b0;
      end
      if (state_q == S_DEC_ARM) begin
        arm_cnt_q <= arm_cnt_q + AW'(1);
      end
      if (state_q == S_RUN) begin
        if (dec_packet_done) begin
          packet_count_q <= sat_inc16(packet_count_q);
        end
        if (dec_done) begin
          dec_seen_q <= 1'b1;
        end
        if (enc_done) begin
          enc_seen_q <= 1'b1;
        end
        // Only the first encoder completion of a transaction is captured.
        if (enc_done && !enc_seen_q) begin
          res_perimiter_q <= enc_perimiter;
          res_area_q      <= enc_area;
          res_x_q         <= enc_start_x;
          res_y_q         <= enc_start_y;
        end
      end
    end
  end

  assign status        = status_q;
  assign packet_count  = packet_count_q;
  assign res_perimiter = res_perimiter_q;
  assign res_area      = res_area_q;
  assign res_x         = res_x_q;
  assign res_y         = res_y_q;

endmodule

// File: tb/tb_chain_link_controller.sv
// Directed bench for chain_link_controller: a cycle table for short
// transactions plus hand-written multi-cycle sequences.
module tb_chain_link_controller;

  logic        clk = 1'b0;
  logic        reset, run, abort;
  logic        enc_start, enc_done, enc_error;
  logic [15:0] enc_perimiter, enc_area;
  logic [5:0]  enc_start_x, enc_start_y;
  logic        dec_reset, dec_start, dec_packet_done, dec_done, dec_error;
  logic        busy, done;
  logic [2:0]  status;
  logic [15:0] packet_count, res_perimiter, res_area;
  logic [5:0]  res_x, res_y;

  always #5 clk = ~clk;

  chain_link_controller #(
    .TIMEOUT_CYCLES  (50),
    .DEC_RESET_CYCLES(2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .run            (run),
    .abort          (abort),
    .enc_start      (enc_start),
    .enc_done       (enc_done),
    .enc_error      (enc_error),
    .enc_perimiter  (enc_perimiter),
    .enc_area       (enc_area),
    .enc_start_x    (enc_start_x),
    .enc_start_y    (enc_start_y),
    .dec_reset      (dec_reset),
    .dec_start      (dec_start),
    .dec_packet_done(dec_packet_done),
    .dec_done       (dec_done),
    .dec_error      (dec_error),
    .busy           (busy),
    .done           (done),
    .status         (status),
    .packet_count   (packet_count),
    .res_perimiter  (res_perimiter),
    .res_area       (res_area),
    .res_x          (res_x),
    .res_y          (res_y)
  );

  typedef struct {
    bit run, abort, enc_err, dec_err, pkt;
    bit busy, enc_start, dec_start, dec_reset, done;
    int status, pkt_cnt;
  } vec_t;

  vec_t vec[19];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input bit r, a, ee, de, p,
                              input bit b, es, ds, dr, dn,
                              input int st, input int pc);
    vec_t v;
    v.run = r; v.abort = a; v.enc_err = ee; v.dec_err = de; v.pkt = p;
    v.busy = b; v.enc_start = es; v.dec_start = ds; v.dec_reset = dr;
    v.done = dn; v.status = st; v.pkt_cnt = pc;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Pulse run and count cycles until enc_start appears; leaves us in ENC_KICK.
  task automatic start_txn(input string tag);
    int n;
    run = 1'b1;
    tick();
    run = 1'b0;
    n = 1;
    while (!enc_start && n < 20) begin
      tick();
      n++;
    end
    chk({tag, " run->enc_start latency"}, n, 3);
  endtask

  // Count cycles (continuing from 'start') until done, bounded by 'limit'.
  task automatic wait_done(input string tag, input int start, input int exp, input int limit);
    int m;
    m = start;
    while (!done && m < limit) begin
      tick();
      m++;
    end
    chk({tag, " done latency"}, m, exp);
    chk({tag, " done"}, int'(done), 1);
  endtask

  task automatic pulse_packets(input int count);
    for (int i = 0; i < count; i++) begin
      dec_packet_done = 1'b1;
      tick();
    end
    dec_packet_done = 1'b0;
  endtask

  initial begin
    int seen_done;

    reset = 1'b1; run = 1'b0; abort = 1'b0;
    enc_done = 1'b0; enc_error = 1'b0; enc_perimiter = '0; enc_area = '0;
    enc_start_x = '0; enc_start_y = '0;
    dec_packet_done = 1'b0; dec_done = 1'b0; dec_error = 1'b0;

    //              run ab ee de pk | busy es ds dr dn st pc
    vec[0]  = mk(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);  // IDLE, accept run
    vec[1]  = mk(0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0, 0);  // DEC_ARM
    vec[2]  = mk(1, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0, 0);  // DEC_ARM, run ignored
    vec[3]  = mk(0, 0, 0, 0, 1,  1, 1, 1, 0, 0, 0, 0);  // ENC_KICK, packet not counted
    vec[4]  = mk(0, 0, 0, 0, 1,  1, 0, 1, 0, 0, 0, 0);  // RUN, packet
    vec[5]  = mk(0, 0, 1, 1, 0,  1, 0, 1, 0, 0, 0, 1);  // RUN, both errors
    vec[6]  = mk(0, 0, 0, 0, 0,  1, 0, 0, 1, 1, 1, 1);  // FINISH ENC_ERR
    vec[7]  = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 1);  // IDLE
    vec[8]  = mk(0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 1, 1);  // IDLE, abort ignored
    vec[9]  = mk(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 1);  // IDLE, no done from abort
    vec[10] = mk(0, 1, 0, 0, 0,  1, 0, 0, 1, 0, 1, 0);  // DEC_ARM, abort, count cleared
    vec[11] = mk(0, 0, 0, 0, 0,  1, 0, 0, 1, 1, 5, 0);  // FINISH ABORT
    vec[12] = mk(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 5, 0);  // IDLE, run
    vec[13] = mk(0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 5, 0);  // DEC_ARM
    vec[14] = mk(0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 5, 0);  // DEC_ARM
    vec[15] = mk(0, 0, 0, 0, 0,  1, 1, 1, 0, 0, 5, 0);  // ENC_KICK
    vec[16] = mk(0, 0, 0, 1, 1,  1, 0, 1, 0, 0, 5, 0);  // RUN, dec_error + packet
    vec[17] = mk(0, 0, 0, 0, 0,  1, 0, 0, 1, 1, 2, 1);  // FINISH DEC_ERR
    vec[18] = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 2, 1);  // IDLE

    tick();
    tick();
    chk("reset busy", int'(busy), 0);
    chk("reset dec_reset", int'(dec_reset), 1);
    chk("reset dec_start", int'(dec_start), 0);
    chk("reset enc_start", int'(enc_start), 0);
    chk("reset done", int'(done), 0);
    chk("reset status", int'(status), 0);
    chk("reset packet_count", int'(packet_count), 0);
    chk("reset res_perimiter", int'(res_perimiter), 0);
    $display("reset: busy=%0b dec_reset=%0b status=%0d", busy, dec_reset, status);
    reset = 1'b0;
    tick();

    for (int i = 0; i < $size(vec); i++) begin
      run = vec[i].run; abort = vec[i].abort; enc_error = vec[i].enc_err;
      dec_error = vec[i].dec_err; dec_packet_done = vec[i].pkt;
      #1;
      chk($sformatf("vec%0d busy", i), int'(busy), int'(vec[i].busy));
      chk($sformatf("vec%0d enc_start", i), int'(enc_start), int'(vec[i].enc_start));
      chk($sformatf("vec%0d dec_start", i), int'(dec_start), int'(vec[i].dec_start));
      chk($sformatf("vec%0d dec_reset", i), int'(dec_reset), int'(vec[i].dec_reset));
      chk($sformatf("vec%0d done", i), int'(done), int'(vec[i].done));
      chk($sformatf("vec%0d status", i), int'(status), vec[i].status);
      chk($sformatf("vec%0d packet_count", i), int'(packet_count), vec[i].pkt_cnt);
      $display("vec%0d: busy=%0b es=%0b ds=%0b dr=%0b done=%0b status=%0d pkts=%0d",
               i, busy, enc_start, dec_start, dec_reset, done, status, packet_count);
      tick();
    end
    run = 1'b0; abort = 1'b0; enc_error = 1'b0; dec_error = 1'b0; dec_packet_done = 1'b0;

    // Normal run: 24 packets matching perimiter 24; run and late enc_done ignored.
    start_txn("normal");
    tick();
    enc_done = 1'b1; enc_perimiter = 16'd24; enc_area = 16'd37;
    enc_start_x = 6'd5; enc_start_y = 6'd9;
    tick();
    enc_done = 1'b0;
    run = 1'b1;
    pulse_packets(12);
    run = 1'b0;
    enc_done = 1'b1; enc_perimiter = 16'd99; enc_area = 16'd1;
    enc_start_x = 6'd63; enc_start_y = 6'd63;
    tick();
    enc_done = 1'b0;
    pulse_packets(12);
    dec_done = 1'b1;
    tick();
    dec_done = 1'b0;
    wait_done("normal", 1, 2, 10);
    chk("normal status", int'(status), 0);
    chk("normal packet_count", int'(packet_count), 24);
    chk("normal res_perimiter", int'(res_perimiter), 24);
    chk("normal res_area", int'(res_area), 37);
    chk("normal res_x", int'(res_x), 5);
    chk("normal res_y", int'(res_y), 9);
    chk("normal dec_start in finish", int'(dec_start), 0);
    chk("normal dec_reset in finish", int'(dec_reset), 0);
    $display("normal: status=%0d pkts=%0d perim=%0d", status, packet_count, res_perimiter);
    tick();
    chk("normal done single cycle", int'(done), 0);
    tick();
    chk("normal idle after run-in-RUN", int'(busy), 0);

    // Mismatch: 23 packets, enc_done and dec_done in the same cycle.
    start_txn("mismatch");
    tick();
    pulse_packets(23);
    enc_done = 1'b1; dec_done = 1'b1; enc_perimiter = 16'd24;
    tick();
    enc_done = 1'b0; dec_done = 1'b0;
    wait_done("mismatch", 1, 2, 10);
    chk("mismatch status", int'(status), 4);
    chk("mismatch dec_reset in finish", int'(dec_reset), 1);
    chk("mismatch packet_count", int'(packet_count), 23);
    $display("mismatch: status=%0d pkts=%0d dec_reset=%0b", status, packet_count, dec_reset);
    tick();

    // Timeout: no enc_done; done 50 cycles after enc_start.
    start_txn("timeout");
    wait_done("timeout", 0, 50, 100);
    chk("timeout status", int'(status), 3);
    chk("timeout dec_reset in finish", int'(dec_reset), 1);
    $display("timeout: status=%0d", status);
    tick();

    // Abort in RUN with a run pulse ignored; abort in IDLE gives no done.
    start_txn("abort");
    tick();
    run = 1'b1;
    tick();
    run = 1'b0;
    pulse_packets(3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort done", int'(done), 1);
    chk("abort status", int'(status), 5);
    chk("abort packet_count", int'(packet_count), 3);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 4; i++) begin
      if (done || busy) seen_done++;
      tick();
    end
    chk("abort idle quiet", seen_done, 0);
    $display("abort: status=%0d pkts=%0d", status, packet_count);

    // Reset in RUN after 10 packets: reset values next cycle, no done.
    start_txn("rst");
    tick();
    enc_done = 1'b1; enc_perimiter = 16'd24; enc_area = 16'd7;
    enc_start_x = 6'd3; enc_start_y = 6'd4;
    tick();
    enc_done = 1'b0;
    pulse_packets(10);
    chk("rst pre count", int'(packet_count), 10);
    reset = 1'b1;
    tick();
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst dec_start", int'(dec_start), 0);
    chk("rst enc_start", int'(enc_start), 0);
    chk("rst dec_reset", int'(dec_reset), 1);
    chk("rst status", int'(status), 0);
    chk("rst packet_count", int'(packet_count), 0);
    chk("rst res_perimiter", int'(res_perimiter), 0);
    chk("rst res_area", int'(res_area), 0);
    chk("rst res_x", int'(res_x), 0);
    chk("rst res_y", int'(res_y), 0);
    reset = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done) seen_done++;
    end
    chk("rst no done after", seen_done, 0);
    chk("rst dec_reset released", int'(dec_reset), 0);
    $display("reset-in-run: busy=%0b pkts=%0d status=%0d", busy, packet_count, status);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
